// File: rtl/morse_beep_sequencer.sv
// Plays one encoded Morse letter on the buzzer with unit-scaled dot/dash/gap timing.
// Optional macro MORSE_SEQ_REPEAT_EN: loop the latched letter while repeat_i is held.
module morse_beep_sequencer #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int TONE_HALF   = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [4:0] code_i,
  input  logic [2:0] len_i,
  input  logic [1:0] speed_i,
  input  logic       abort_i,
  input  logic       repeat_i,
  output logic       beep_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] sym_idx_o
);

  // Longest interval is a 3-unit dash or letter gap at the slowest speed.
  localparam longint MAX_DUR = 3 * (longint'(UNIT_CYCLES) << 3);
  localparam int     DW_FIT  = $clog2(MAX_DUR + 1);
  localparam int     DW      = (DW_FIT > 27) ? DW_FIT : 27;
  localparam int     TW      = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_LGAP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    sym_q, sym_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          beep_q, beep_d;
  logic          done_q, done_d;
  logic [4:0]    code_q, code_d;
  logic [2:0]    len_q, len_d;
  logic [1:0]    spd_q, spd_d;

  logic [DW-1:0] unit, dur;
  logic          last, len_ok, rep;

`ifdef MORSE_SEQ_REPEAT_EN
  assign rep = repeat_i;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_i;
  assign rep           = 1'b0;
`endif

  assign unit   = DW'(UNIT_CYCLES) << spd_q;
  assign len_ok = (len_i != 3'd0) && (len_i <= 3'd5);
  assign last   = (cnt_q == dur - DW'(1));

  always_comb begin
    dur = unit;
    case (state_q)
      S_TONE:  dur = code_q[sym_q] ? (unit + (unit << 1)) : unit;
      S_LGAP:  dur = unit + (unit << 1);
      default: dur = unit;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    beep_d  = beep_q;
    done_d  = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    spd_d   = spd_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && len_ok) begin
          code_d  = code_i;
          len_d   = len_i;
          spd_d   = speed_i;
          state_d = S_TONE;
          sym_d   = 3'd0;
          cnt_d   = '0;
          tcnt_d  = '0;
          beep_d  = 1'b1;
        end
      end
      S_TONE: begin
        if (last) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          beep_d  = 1'b0;
          state_d = (sym_q == len_q - 3'd1) ? S_LGAP : S_GAP;
        end else begin
          cnt_d = cnt_q + DW'(1);
          if (tcnt_q == TW'(TONE_HALF - 1)) begin
            tcnt_d = '0;
            beep_d = ~beep_q;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_GAP: begin
        if (last) begin
          cnt_d   = '0;
          sym_d   = sym_q + 3'd1;
          state_d = S_TONE;
          beep_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        if (last) begin
          cnt_d = '0;
          sym_d = 3'd0;
          if (rep) begin
            state_d = S_TONE;
            beep_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    endcase
    // Abort overrides whatever transition was chosen above.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sym_d   = 3'd0;
      cnt_d   = '0;
      tcnt_d  = '0;
      beep_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sym_q   <= 3'd0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      beep_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= 5'd0;
      len_q   <= 3'd0;
      spd_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      beep_q  <= beep_d;
      done_q  <= done_d;
      code_q  <= code_d;
      len_q   <= len_d;
      spd_q   <= spd_d;
    end
  end

  assign beep_o    = beep_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign sym_idx_o = sym_q;

endmodule

// File: tb/tb_morse_beep_sequencer.sv
// Scoreboard bench for morse_beep_sequencer: per-cycle output trace plus hand-timed done pulses.
module tb_morse_beep_sequencer;
  localparam int UC = 4;
  localparam int TH = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start_i = 1'b0, abort_i = 1'b0, repeat_i = 1'b0;
  logic [4:0] code_i = 5'd0;
  logic [2:0] len_i = 3'd0;
  logic [1:0] speed_i = 2'd0;
  logic       beep_o, busy_o, done_o;
  logic [2:0] sym_idx_o;

  morse_beep_sequencer #(.UNIT_CYCLES(UC), .TONE_HALF(TH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .code_i(code_i), .len_i(len_i),
    .speed_i(speed_i), .abort_i(abort_i), .repeat_i(repeat_i),
    .beep_o(beep_o), .busy_o(busy_o), .done_o(done_o), .sym_idx_o(sym_idx_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       beep;
    logic       busy;
    logic       done;
    logic [2:0] sym;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   nvec = 0, nerr = 0;

  task automatic push(int c, logic b, logic bz, logic d, logic [2:0] s);
    exp_t e;
    e.cyc = c; e.beep = b; e.busy = bz; e.done = d; e.sym = s;
    exp_q.push_back(e);
  endtask

  // Letter model state, used only by the stimulus process.
  int mt, mstop_at;
  bit mstop;

  task automatic madd(logic b, logic [2:0] s);
    if (mstop) return;
    if (mstop_at >= 0 && mt > mstop_at) begin
      push(mt, 1'b0, 1'b0, 1'b0, 3'd0);
      mstop = 1'b1;
      return;
    end
    push(mt, b, 1'b1, 1'b0, s);
    mt++;
  endtask

  task automatic expect_letter(int n, logic [4:0] code, int len, int spd, int stop_at, bit tail);
    int unit, d;
    unit = UC << spd;
    mt = n + 1; mstop_at = stop_at; mstop = 1'b0;
    for (int s = 0; s < len; s++) begin
      d = code[s] ? 3 * unit : unit;
      for (int k = 0; k < d; k++) madd(((k / TH) % 2) == 0, 3'(s));
      if (s < len - 1)
        for (int k = 0; k < unit; k++) madd(1'b0, 3'(s));
    end
    for (int k = 0; k < 3 * unit; k++) madd(1'b0, 3'(len - 1));
    if (tail && !mstop) push(mt, 1'b0, 1'b0, 1'b1, 3'd0);
  endtask

  task automatic push_idle(int from, int to);
    for (int c = from; c <= to; c++) push(c, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      nvec++; nerr++;
      $display("FAIL trace_skipped cyc=%0d expected entry never sampled", e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      nvec++;
      if (beep_o !== e.beep || busy_o !== e.busy || done_o !== e.done || sym_idx_o !== e.sym) begin
        nerr++;
        $display("FAIL trace cyc=%0d got beep=%b busy=%b done=%b sym=%0d want beep=%b busy=%b done=%b sym=%0d",
                 cyc, beep_o, busy_o, done_o, sym_idx_o, e.beep, e.busy, e.done, e.sym);
      end
    end
    if (done_o === 1'b1) begin
      nvec++;
      if (done_q.size() > 0 && done_q[0] == cyc) void'(done_q.pop_front());
      else begin
        nerr++;
        $display("FAIL done_pulse got done at cyc=%0d want done at cyc=%0d", cyc,
                 (done_q.size() > 0) ? done_q[0] : -1);
      end
    end
  end

  task automatic go(logic [4:0] c, logic [2:0] l, logic [1:0] s);
    code_i = c; len_i = l; speed_i = s; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0) && k < 500) begin
      @(negedge clk); k++;
    end
    if (k >= 500) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout got %0d trace/%0d done pending want 0", exp_q.size(), done_q.size());
      exp_q.delete(); done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    push_idle(cyc + 1, cyc + 3);
    rst = 1'b0;
    drain();

    // Dot, then a new dot started on the done cycle.
    n = cyc;
    expect_letter(n, 5'b00000, 1, 0, -1, 1'b1);
    done_q.push_back(n + 17);
    go(5'b00000, 3'd1, 2'd0);
    wait_cyc(n + 17);
    expect_letter(n + 17, 5'b00000, 1, 0, -1, 1'b1);
    done_q.push_back(n + 34);
    go(5'b00000, 3'd1, 2'd0);
    drain();

    // Letter A (.-)
    n = cyc;
    expect_letter(n, 5'b00010, 2, 0, -1, 1'b1);
    done_q.push_back(n + 33);
    go(5'b00010, 3'd2, 2'd0);
    drain();

    // Dot at speed 2, speed dropped mid-letter
    n = cyc;
    expect_letter(n, 5'b00000, 1, 2, -1, 1'b1);
    done_q.push_back(n + 65);
    go(5'b00000, 3'd1, 2'd2);
    wait_cyc(n + 6);
    speed_i = 2'd0;
    drain();

    // Letter 0 (-----) with ignored restart at N+10 and abort at N+20
    n = cyc;
    expect_letter(n, 5'b11111, 5, 0, n + 20, 1'b0);
    push_idle(n + 22, n + 26);
    go(5'b11111, 3'd5, 2'd0);
    wait_cyc(n + 10);
    go(5'b00000, 3'd1, 2'd0);
    wait_cyc(n + 20);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    drain();

    // Illegal lengths
    n = cyc;
    push_idle(n + 1, n + 4);
    go(5'b00101, 3'd0, 2'd0);
    drain();
    n = cyc;
    push_idle(n + 1, n + 4);
    go(5'b00101, 3'd6, 2'd0);
    drain();

    // Reset mid-letter
    n = cyc;
    expect_letter(n, 5'b00001, 1, 0, n + 3, 1'b0);
    push_idle(n + 5, n + 6);
    go(5'b00001, 3'd1, 2'd0);
    wait_cyc(n + 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();

    // Repeat request held through the first letter gap
    n = cyc;
`ifdef MORSE_SEQ_REPEAT_EN
    expect_letter(n, 5'b00000, 1, 0, -1, 1'b0);
    expect_letter(n + 16, 5'b00000, 1, 0, -1, 1'b1);
    done_q.push_back(n + 33);
`else
    expect_letter(n, 5'b00000, 1, 0, -1, 1'b1);
    push_idle(n + 18, n + 22);
    done_q.push_back(n + 17);
`endif
    repeat_i = 1'b1;
    go(5'b00000, 3'd1, 2'd0);
    wait_cyc(n + 20);
    repeat_i = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
